hazard_scoreboard: RTL and testbench

//  Parametrised hazard unit for the 5-stage pipeline. Successor to the single-purpose load-use/multdiv stall logic.
//  - Detects load-use hazards and generates forwarding selects for both ALU operands.
//  - Tracks one in-flight multi-cycle mul/div with a scoreboarded destination register, a watchdog and a writeback-port handshake.
//  - Placement: beside the F/D and D/X pipeline registers; drives PC/F-D freeze, D/X bubble insert, bypass muxes and the regfile write mux.

---
 rtl/hazard_pkg.sv | 84 ++++++++
 rtl/multdiv_tracker.sv | 105 ++++++++++
 rtl/hazard_scoreboard.sv | 96 +++++++++
 tb/tb_hazard_scoreboard.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared decode helpers, opcode constants and FSM state encoding for the pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned INSN_W    = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned OP_W      = 5;
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned ALUOP_LSB = 2;

    typedef logic [INSN_W-1:0] insn_t;
    typedef logic [REG_W-1:0]  reg_t;
    typedef logic [OP_W-1:0]   op_t;

    localparam op_t OP_RTYPE = 5'b00000;
    localparam op_t OP_BNE   = 5'b00010;
    localparam op_t OP_ADDI  = 5'b00101;
    localparam op_t OP_BLT   = 5'b00110;
    localparam op_t OP_SW    = 5'b00111;
    localparam op_t OP_LW    = 5'b01000;
    localparam op_t ALU_MUL  = 5'b00110;
    localparam op_t ALU_DIV  = 5'b00111;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_XM = 2'b01;
    localparam logic [1:0] FWD_MW = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_e;

    function automatic op_t opcode_of(input insn_t i);
        return i[OP_LSB +: OP_W];
    endfunction

    function automatic reg_t rd_of(input insn_t i);
        return i[RD_LSB +: REG_W];
    endfunction

    function automatic reg_t rs_of(input insn_t i);
        return i[RS_LSB +: REG_W];
    endfunction

    function automatic op_t aluop_of(input insn_t i);
        return i[ALUOP_LSB +: OP_W];
    endfunction

    function automatic logic is_lw(input insn_t i);
        return opcode_of(i) == OP_LW;
    endfunction

    function automatic logic writes_rd(input insn_t i);
        op_t op;
        op = opcode_of(i);
        return ((op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW)) && (rd_of(i) != '0);
    endfunction

    function automatic logic reads_rs(input insn_t i);
        op_t op;
        op = opcode_of(i);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT);
    endfunction

    function automatic logic reads_rt(input insn_t i);
        op_t op;
        op = opcode_of(i);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT);
    endfunction

    // Stores and branches carry their second source in the rd field.
    function automatic reg_t src2_of(input insn_t i);
        return (opcode_of(i) == OP_RTYPE) ? i[RT_LSB +: REG_W] : rd_of(i);
    endfunction

    function automatic logic is_multdiv(input insn_t i);
        return (opcode_of(i) == OP_RTYPE) && ((aluop_of(i) == ALU_MUL) || (aluop_of(i) == ALU_DIV));
    endfunction

    function automatic logic reads_reg(input insn_t i, input reg_t r);
        return (r != '0) && ((reads_rs(i) && (rs_of(i) == r)) || (reads_rt(i) && (src2_of(i) == r)));
    endfunction

endpackage

// File: rtl/multdiv_tracker.sv
// Tracks one outstanding mul/div: launch, watchdog abort, and arbitration for the writeback port.
module multdiv_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic  clock,
    input  logic  reset,
    input  insn_t fd_insn,
    input  insn_t dx_insn,
    input  logic  mw_writes,
    input  logic  multdiv_rdy,
    output logic  md_stall,
    output logic  md_start,
    output logic  md_busy,
    output logic  md_wb_ena,
    output reg_t  md_rd,
    output logic  md_timeout
);

    localparam int unsigned WD_W = $clog2(MD_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    md_state_e       state, state_nxt;
    logic [WD_W-1:0] wd, wd_nxt;
    reg_t            md_rd_nxt;
    logic            fd_hit;
    logic            dx_launch;
    logic            unused_insn_bits;

    assign unused_insn_bits = ^{fd_insn, dx_insn};

    assign dx_launch = is_multdiv(dx_insn);
    assign fd_hit    = reads_reg(fd_insn, md_rd) ||
                       (writes_rd(fd_insn) && (rd_of(fd_insn) == md_rd)) ||
                       is_multdiv(fd_insn);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            wd    <= '0;
            md_rd <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
            md_rd <= md_rd_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wd_nxt     = wd;
        md_rd_nxt  = md_rd;
        md_stall   = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_wb_ena  = 1'b0;
        md_timeout = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (dx_launch) begin
                        md_start  = 1'b1;
                        md_rd_nxt = rd_of(dx_insn);
                        wd_nxt    = '0;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    md_busy  = 1'b1;
                    md_stall = fd_hit;
                    wd_nxt   = wd + WD_W'(1);
                    if (multdiv_rdy) begin
                        state_nxt = DONE;
                    end else if (wd == WD_LAST) begin
                        md_timeout = 1'b1;
                        md_rd_nxt  = '0;
                        wd_nxt     = '0;
                        state_nxt  = IDLE;
                    end
                end
                DONE: begin
                    md_busy = 1'b1;
                    if (mw_writes) begin
                        md_stall = 1'b1;
                    end else begin
                        // Same-cycle fd read of md_rd relies on write-before-read regfile.
                        md_wb_ena = (md_rd != '0);
                        if (dx_launch) begin
                            md_start  = 1'b1;
                            md_rd_nxt = rd_of(dx_insn);
                            wd_nxt    = '0;
                            state_nxt = BUSY;
                        end else begin
                            md_rd_nxt = '0;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use detection, ALU operand forwarding and mul/div scoreboarding.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REGW       = 5,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter bit          FWD_EN     = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] fd_insn,
    input  logic [XLEN-1:0] dx_insn,
    input  logic [XLEN-1:0] xm_insn,
    input  logic [XLEN-1:0] mw_insn,
    input  logic            multdiv_RDY,
    output logic            stall_fd,
    output logic            flush_dx,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            md_start,
    output logic            md_busy,
    output logic            md_wb_ena,
    output logic [REGW-1:0] md_rd,
    output logic            md_timeout
);

    insn_t fd, dx, xm, mw;
    reg_t  md_rd_q;
    logic  load_use, raw_stall, md_stall;
    logic  xm_fwd, mw_fwd;
    logic  unused_insn_bits;

    assign fd = INSN_W'(fd_insn);
    assign dx = INSN_W'(dx_insn);
    assign xm = INSN_W'(xm_insn);
    assign mw = INSN_W'(mw_insn);
    assign unused_insn_bits = ^{fd, dx, xm, mw};

    multdiv_tracker #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_tracker (
        .clock       (clock),
        .reset       (reset),
        .fd_insn     (fd),
        .dx_insn     (dx),
        .mw_writes   (writes_rd(mw)),
        .multdiv_rdy (multdiv_RDY),
        .md_stall    (md_stall),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .md_wb_ena   (md_wb_ena),
        .md_rd       (md_rd_q),
        .md_timeout  (md_timeout)
    );

    assign md_rd = REGW'(md_rd_q);

    // Without forwarding, any consumer of a producer still ahead of writeback waits in decode.
    always_comb begin
        load_use  = is_lw(dx) && writes_rd(dx) && reads_reg(fd, rd_of(dx));
        raw_stall = 1'b0;
        if (!FWD_EN) begin
            raw_stall = (writes_rd(dx) && reads_reg(fd, rd_of(dx))) ||
                        (writes_rd(xm) && reads_reg(fd, rd_of(xm)));
        end
    end

    assign stall_fd = !reset && (load_use || raw_stall || md_stall);
    assign flush_dx = stall_fd;

    // XM beats MW; a load still in XM has no data to forward.
    always_comb begin
        xm_fwd    = writes_rd(xm) && !is_lw(xm);
        mw_fwd    = writes_rd(mw);
        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (FWD_EN && !reset) begin
            if (reads_rs(dx)) begin
                if (xm_fwd && (rd_of(xm) == rs_of(dx))) begin
                    fwd_a_sel = FWD_XM;
                end else if (mw_fwd && (rd_of(mw) == rs_of(dx))) begin
                    fwd_a_sel = FWD_MW;
                end
            end
            if (reads_rt(dx)) begin
                if (xm_fwd && (rd_of(xm) == src2_of(dx))) begin
                    fwd_b_sel = FWD_XM;
                end else if (mw_fwd && (rd_of(mw) == src2_of(dx))) begin
                    fwd_b_sel = FWD_MW;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances (default, short watchdog, no forwarding).
module tb_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_insn, dx_insn, xm_insn, mw_insn;
    logic        multdiv_RDY;

    logic       s_stall, s_flush, s_md_start, s_md_busy, s_md_wb_ena, s_md_timeout;
    logic [1:0] s_fwd_a, s_fwd_b;
    logic [4:0] s_md_rd;
    logic       t_stall, t_flush, t_md_start, t_md_busy, t_md_wb_ena, t_md_timeout;
    logic [1:0] t_fwd_a, t_fwd_b;
    logic [4:0] t_md_rd;
    logic       n_stall, n_flush, n_md_start, n_md_busy, n_md_wb_ena, n_md_timeout;
    logic [1:0] n_fwd_a, n_fwd_b;
    logic [4:0] n_md_rd;

    int checks = 0;
    int fails  = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [4:0]  MUL = 5'b00110;
    localparam logic [4:0]  DIV = 5'b00111;

    always #5 clock = ~clock;

    hazard_scoreboard #(.MD_TIMEOUT(64), .FWD_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn),
        .mw_insn(mw_insn), .multdiv_RDY(multdiv_RDY), .stall_fd(s_stall), .flush_dx(s_flush),
        .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b), .md_start(s_md_start), .md_busy(s_md_busy),
        .md_wb_ena(s_md_wb_ena), .md_rd(s_md_rd), .md_timeout(s_md_timeout));

    hazard_scoreboard #(.MD_TIMEOUT(8), .FWD_EN(1'b1)) dut_t (
        .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn),
        .mw_insn(mw_insn), .multdiv_RDY(multdiv_RDY), .stall_fd(t_stall), .flush_dx(t_flush),
        .fwd_a_sel(t_fwd_a), .fwd_b_sel(t_fwd_b), .md_start(t_md_start), .md_busy(t_md_busy),
        .md_wb_ena(t_md_wb_ena), .md_rd(t_md_rd), .md_timeout(t_md_timeout));

    hazard_scoreboard #(.MD_TIMEOUT(64), .FWD_EN(1'b0)) dut_n (
        .clock(clock), .reset(reset), .fd_insn(fd_insn), .dx_insn(dx_insn), .xm_insn(xm_insn),
        .mw_insn(mw_insn), .multdiv_RDY(multdiv_RDY), .stall_fd(n_stall), .flush_dx(n_flush),
        .fwd_a_sel(n_fwd_a), .fwd_b_sel(n_fwd_b), .md_start(n_md_start), .md_busy(n_md_busy),
        .md_wb_ena(n_md_wb_ena), .md_rd(n_md_rd), .md_timeout(n_md_timeout));

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs);
        return {op, rd, rs, 17'd4};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive(input logic [31:0] fd, input logic [31:0] dx, input logic [31:0] xm, input logic [31:0] mw);
        fd_insn = fd;
        dx_insn = dx;
        xm_insn = xm;
        mw_insn = mw;
    endtask

    task automatic do_reset;
        reset       = 1'b1;
        multdiv_RDY = 1'b0;
        drive(NOP, NOP, NOP, NOP);
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        multdiv_RDY = 1'b0;
        drive(rtype(4, 3, 5, 0), itype(5'b01000, 3, 1), NOP, NOP);
        tick;
        drive(NOP, rtype(7, 1, 2, MUL), NOP, NOP);
        settle;
        checks++;
        if ({s_stall, s_flush, s_md_start, s_md_busy} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_hold: got %b want 0000", {s_stall, s_flush, s_md_start, s_md_busy});
        end
        tick;
        reset = 1'b0;
        drive(NOP, NOP, NOP, NOP);
        settle;
        checks++;
        if ({s_stall, s_fwd_a, s_fwd_b, s_md_busy, s_md_wb_ena, s_md_rd, s_md_timeout} !== 12'd0) begin
            fails++;
            $display("FAIL rst_state: got busy=%b rd=%0d stall=%b want all 0", s_md_busy, s_md_rd, s_stall);
        end
    endtask

    task automatic test_load_use;
        do_reset;
        drive(rtype(4, 3, 5, 0), itype(5'b01000, 3, 1), NOP, NOP);
        settle;
        checks++;
        if ({s_stall, s_flush} !== 2'b11) begin
            fails++;
            $display("FAIL lu_stall: got %b want 11", {s_stall, s_flush});
        end
        tick;
        drive(rtype(4, 3, 5, 0), NOP, itype(5'b01000, 3, 1), NOP);
        settle;
        checks++;
        if (s_stall !== 1'b0) begin
            fails++;
            $display("FAIL lu_release: got %b want 0", s_stall);
        end
        tick;
        drive(NOP, rtype(4, 3, 5, 0), NOP, itype(5'b01000, 3, 1));
        settle;
        checks++;
        if ({s_fwd_a, s_fwd_b} !== 4'b1000) begin
            fails++;
            $display("FAIL lu_fwd: got %b/%b want 10/00", s_fwd_a, s_fwd_b);
        end
        tick;
        drive(rtype(4, 1, 5, 0), itype(5'b01000, 3, 1), NOP, NOP);
        settle;
        checks++;
        if (s_stall !== 1'b0) begin
            fails++;
            $display("FAIL lu_indep: got %b want 0", s_stall);
        end
        tick;
        drive(rtype(4, 0, 0, 0), itype(5'b01000, 0, 1), NOP, NOP);
        settle;
        checks++;
        if (s_stall !== 1'b0) begin
            fails++;
            $display("FAIL lu_r0: got %b want 0", s_stall);
        end
    endtask

    task automatic test_forwarding;
        do_reset;
        drive(rtype(4, 3, 3, 0), rtype(4, 3, 3, 0), rtype(3, 1, 2, 0), itype(5'b00101, 3, 1));
        settle;
        checks++;
        if ({s_fwd_a, s_fwd_b} !== 4'b0101) begin
            fails++;
            $display("FAIL fwd_xm: got %b/%b want 01/01", s_fwd_a, s_fwd_b);
        end
        checks++;
        if (s_stall !== 1'b0) begin
            fails++;
            $display("FAIL fwd_nostall: got %b want 0", s_stall);
        end
        tick;
        drive(rtype(4, 3, 3, 0), rtype(4, 3, 3, 0), NOP, itype(5'b00101, 3, 1));
        settle;
        checks++;
        if ({s_fwd_a, s_fwd_b} !== 4'b1010) begin
            fails++;
            $display("FAIL fwd_mw: got %b/%b want 10/10", s_fwd_a, s_fwd_b);
        end
        tick;
        drive(rtype(4, 0, 0, 0), rtype(4, 0, 0, 0), rtype(0, 1, 2, 0), itype(5'b00101, 0, 1));
        settle;
        checks++;
        if ({s_fwd_a, s_fwd_b} !== 4'b0000) begin
            fails++;
            $display("FAIL fwd_r0: got %b/%b want 00/00", s_fwd_a, s_fwd_b);
        end
        tick;
        drive(NOP, rtype(4, 3, 3, 0), itype(5'b01000, 3, 1), NOP);
        settle;
        checks++;
        if ({s_fwd_a, s_fwd_b} !== 4'b0000) begin
            fails++;
            $display("FAIL fwd_xm_lw: got %b/%b want 00/00", s_fwd_a, s_fwd_b);
        end
        tick;
        drive(NOP, itype(5'b00111, 3, 1), rtype(3, 1, 2, 0), NOP);
        settle;
        checks++;
        if ({s_fwd_a, s_fwd_b} !== 4'b0001) begin
            fails++;
            $display("FAIL fwd_sw_src2: got %b/%b want 00/01", s_fwd_a, s_fwd_b);
        end
    endtask

    task automatic test_no_forward;
        do_reset;
        drive(rtype(4, 3, 5, 0), NOP, rtype(3, 1, 2, 0), NOP);
        settle;
        checks++;
        if ({n_stall, n_flush, s_stall} !== 3'b110) begin
            fails++;
            $display("FAIL nofwd_stall: got nf=%b%b fwd=%b want 11/0", n_stall, n_flush, s_stall);
        end
        tick;
        drive(NOP, rtype(4, 3, 5, 0), rtype(3, 1, 2, 0), NOP);
        settle;
        checks++;
        if ({n_fwd_a, s_fwd_a} !== 4'b0001) begin
            fails++;
            $display("FAIL nofwd_sel: got nf=%b fwd=%b want 00/01", n_fwd_a, s_fwd_a);
        end
    endtask

    task automatic test_multdiv_busy;
        do_reset;
        drive(NOP, rtype(7, 1, 2, MUL), NOP, NOP);
        settle;
        checks++;
        if ({s_md_start, s_md_busy, s_stall} !== 3'b100) begin
            fails++;
            $display("FAIL md_launch: got %b want 100", {s_md_start, s_md_busy, s_stall});
        end
        tick;
        drive(rtype(8, 7, 1, 0), NOP, NOP, NOP);
        settle;
        checks++;
        if ({s_md_start, s_md_rd} !== {1'b0, 5'd7}) begin
            fails++;
            $display("FAIL md_rd: got start=%b rd=%0d want 0/7", s_md_start, s_md_rd);
        end
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin
                tick;
                settle;
            end
            checks++;
            if ({s_stall, s_flush, s_md_busy, s_md_wb_ena} !== 4'b1110) begin
                fails++;
                $display("FAIL md_busy_stall c%0d: got %b want 1110", c, {s_stall, s_flush, s_md_busy, s_md_wb_ena});
            end
        end
        tick;
        multdiv_RDY = 1'b1;
        settle;
        checks++;
        if ({s_stall, s_md_wb_ena} !== 2'b10) begin
            fails++;
            $display("FAIL md_rdy_cycle: got %b want 10", {s_stall, s_md_wb_ena});
        end
        tick;
        settle;
        checks++;
        if ({s_md_wb_ena, s_stall, s_md_busy} !== 3'b101) begin
            fails++;
            $display("FAIL md_wb: got %b want 101", {s_md_wb_ena, s_stall, s_md_busy});
        end
        tick;
        multdiv_RDY = 1'b0;
        settle;
        checks++;
        if ({s_md_busy, s_md_wb_ena, s_stall} !== 3'b000) begin
            fails++;
            $display("FAIL md_idle: got %b want 000", {s_md_busy, s_md_wb_ena, s_stall});
        end
    endtask

    task automatic test_timeout;
        do_reset;
        drive(NOP, rtype(9, 1, 2, DIV), NOP, NOP);
        settle;
        checks++;
        if (t_md_start !== 1'b1) begin
            fails++;
            $display("FAIL to_launch: got %b want 1", t_md_start);
        end
        tick;
        drive(rtype(10, 9, 0, 0), NOP, NOP, NOP);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick;
            settle;
            checks++;
            if ({t_md_timeout, t_stall} !== {(c == 8), 1'b1}) begin
                fails++;
                $display("FAIL to_cycle c%0d: got to=%b stall=%b want to=%b stall=1", c, t_md_timeout, t_stall, (c == 8));
            end
        end
        tick;
        settle;
        checks++;
        if ({t_md_busy, t_stall, t_md_wb_ena, t_md_timeout, t_md_rd} !== 9'd0) begin
            fails++;
            $display("FAIL to_after: got busy=%b stall=%b wb=%b to=%b rd=%0d want all 0", t_md_busy, t_stall, t_md_wb_ena, t_md_timeout, t_md_rd);
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        drive(NOP, rtype(5, 1, 2, MUL), NOP, NOP);
        tick;
        drive(NOP, NOP, NOP, NOP);
        multdiv_RDY = 1'b1;
        tick;
        drive(NOP, NOP, NOP, itype(5'b00101, 2, 1));
        settle;
        checks++;
        if ({s_stall, s_flush, s_md_wb_ena, s_md_busy} !== 4'b1101) begin
            fails++;
            $display("FAIL b2b_defer: got %b want 1101", {s_stall, s_flush, s_md_wb_ena, s_md_busy});
        end
        tick;
        multdiv_RDY = 1'b0;
        drive(NOP, rtype(6, 1, 2, DIV), NOP, NOP);
        settle;
        checks++;
        if ({s_md_wb_ena, s_md_start, s_stall} !== 3'b110) begin
            fails++;
            $display("FAIL b2b_wb: got %b want 110", {s_md_wb_ena, s_md_start, s_stall});
        end
        tick;
        drive(NOP, NOP, NOP, NOP);
        settle;
        checks++;
        if ({s_md_busy, s_md_start, s_md_wb_ena, s_md_rd} !== {3'b100, 5'd6}) begin
            fails++;
            $display("FAIL b2b_busy: got busy=%b start=%b wb=%b rd=%0d want 1/0/0/6", s_md_busy, s_md_start, s_md_wb_ena, s_md_rd);
        end
    endtask

    task automatic test_reset_mid_op;
        do_reset;
        drive(NOP, rtype(11, 1, 2, MUL), NOP, NOP);
        tick;
        drive(NOP, NOP, NOP, NOP);
        settle;
        checks++;
        if (s_md_busy !== 1'b1) begin
            fails++;
            $display("FAIL rmid_busy: got %b want 1", s_md_busy);
        end
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        settle;
        checks++;
        if ({s_stall, s_flush, s_fwd_a, s_fwd_b, s_md_start, s_md_busy, s_md_wb_ena, s_md_rd, s_md_timeout} !== 15'd0) begin
            fails++;
            $display("FAIL rmid_clear: got busy=%b rd=%0d wb=%b to=%b want all 0", s_md_busy, s_md_rd, s_md_wb_ena, s_md_timeout);
        end
        multdiv_RDY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            settle;
            checks++;
            if ({s_md_busy, s_md_wb_ena} !== 2'b00) begin
                fails++;
                $display("FAIL rmid_rdy c%0d: got %b want 00", c, {s_md_busy, s_md_wb_ena});
            end
        end
        multdiv_RDY = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        multdiv_RDY = 1'b0;
        drive(NOP, NOP, NOP, NOP);
        tick;
        test_reset;
        test_load_use;
        test_forwarding;
        test_no_forward;
        test_multdiv_busy;
        test_timeout;
        test_back_to_back;
        test_reset_mid_op;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
